// File: rtl/parking_gate_pkg.sv
// Shared types and default constants for the parking-gate controller.
package parking_gate_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VERIFY = 3'd1,
    OPEN   = 3'd2,
    BLOCK  = 3'd3,
    LOCK   = 3'd4
  } state_t;

  localparam int DEF_PIN_W         = 16;
  localparam int DEF_MAX_ATTEMPTS  = 3;
  localparam int DEF_WARN_ATTEMPTS = 2;
  localparam int DEF_LOCK_CYCLES   = 64;

endpackage

// File: rtl/parking_lock_timer.sv
// Lockout down-counter: loaded on LOCK entry, counts while LOCK is held,
// and flags expiry in the last LOCK cycle so LOCK lasts exactly LOCK_CYCLES cycles.
module parking_lock_timer
  import parking_gate_pkg::*;
#(
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic expired
);

  localparam int CW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(LOCK_CYCLES - 1);
    end else if (run && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expired = run && (cnt == '0);

endmodule

// File: rtl/parking_gate_ctrl.sv
// Parking-gate controller: PIN check, open/close, failed-try warning/lockout, tailgate block.
// Define PARKING_LOCK_TIMEOUT_EN to make LOCK time out after LOCK_CYCLES; otherwise only rst leaves LOCK.
module parking_gate_ctrl
  import parking_gate_pkg::*;
#(
  parameter int PIN_W         = DEF_PIN_W,
  parameter int MAX_ATTEMPTS  = DEF_MAX_ATTEMPTS,
  parameter int WARN_ATTEMPTS = DEF_WARN_ATTEMPTS,
  parameter int LOCK_CYCLES   = DEF_LOCK_CYCLES,
  parameter int ATT_W         = $clog2(MAX_ATTEMPTS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s01,
  input  logic             s02,
  // pin_valid is a one-cycle strobe with no backpressure: pass is taken on the
  // edge where pin_valid is high, and only VERIFY and BLOCK look at it.
  input  logic             pin_valid,
  input  logic [PIN_W-1:0] pass,
  input  logic [PIN_W-1:0] rghtpss,
  output logic             gate,
  output logic             wrong_pin_alarm,
  output logic             lock_alarm,
  output logic             block_alarm,
  output logic [ATT_W-1:0] attempts,
  output state_t           state_dbg
);

  localparam logic [ATT_W-1:0] WARN_L = ATT_W'(WARN_ATTEMPTS);
  localparam logic [ATT_W-1:0] MAX_L  = ATT_W'(MAX_ATTEMPTS);

  if (MAX_ATTEMPTS < 1 || WARN_ATTEMPTS > MAX_ATTEMPTS || LOCK_CYCLES < 1) begin : g_bad_cfg
    $error("parking_gate_ctrl: invalid attempt/lock parameters");
  end

  state_t           state, state_n;
  logic [ATT_W-1:0] att_n, att_inc;
  logic             warn_n;
  logic             match;
  logic             lock_done;

  assign match     = (pass == rghtpss);
  assign att_inc   = attempts + ATT_W'(1);
  assign state_dbg = state;

`ifdef PARKING_LOCK_TIMEOUT_EN
  logic lock_load;

  assign lock_load = (state_n == LOCK) && (state != LOCK);

  parking_lock_timer #(
    .LOCK_CYCLES(LOCK_CYCLES)
  ) u_lock_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (lock_load),
    .run    (state == LOCK),
    .expired(lock_done)
  );
`else
  assign lock_done = 1'b0;
`endif

  always_comb begin
    state_n = state;
    att_n   = attempts;
    warn_n  = wrong_pin_alarm;
    case (state)
      IDLE: begin
        if (s01) begin
          state_n = VERIFY;
          att_n   = '0;
        end
      end
      VERIFY: begin
        if (pin_valid) begin
          if (match) begin
            state_n = OPEN;
            att_n   = '0;
            warn_n  = 1'b0;
          end else begin
            att_n = att_inc;
            if (att_inc >= WARN_L) warn_n = 1'b1;
            // att_inc never exceeds MAX_L: VERIFY is only reached below MAX.
            if (att_inc == MAX_L) begin
              state_n = LOCK;
              warn_n  = 1'b1;
            end
          end
        end
      end
      OPEN: begin
        // Tailgating outranks the normal close.
        if (s01 && s02) state_n = BLOCK;
        else if (s02)   state_n = IDLE;
      end
      BLOCK: begin
        if (pin_valid && match) state_n = IDLE;
      end
      LOCK: begin
        if (lock_done) begin
          state_n = IDLE;
          att_n   = '0;
          warn_n  = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        att_n   = '0;
        warn_n  = 1'b0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      attempts        <= '0;
      wrong_pin_alarm <= 1'b0;
      gate            <= 1'b0;
      lock_alarm      <= 1'b0;
      block_alarm     <= 1'b0;
    end else begin
      state           <= state_n;
      attempts        <= att_n;
      wrong_pin_alarm <= warn_n;
      gate            <= (state_n == OPEN);
      lock_alarm      <= (state_n == LOCK);
      block_alarm     <= (state_n == BLOCK);
    end
  end

endmodule
